jtpang_eeprom93: RTL and testbench
==================================

// Module: jtpang_eeprom93
// PURPOSE
//  Serial EEPROM responder, 93C46-compatible, x16 organisation. It is the device end of the
//  scs/sclk/sdi/sdo link that the main CPU bit-bangs through I/O ports 08h/10h/18h.
//  It holds 2^AW words of game settings and high scores. A dump port lets the frame
//  restore and save the contents from/to the SD card. A dirty flag requests a save.
// PARAMETERS
//  DW        16     data word width, bits
//  AW        6      word address width; array depth is 2^AW words
//  BUSY_CNT  4096   clk cycles of programming time after WRITE/ERASE/ERAL/WRAL
// PORTS
//  clk        in   1   system clock, 48MHz; all logic is synchronous to it
//  rst        in   1   reset, asynchronous, active-high
//  scs        in   1   chip select, active high
//  sclk       in   1   serial clock from CPU latch (slow; sampled on clk)
//  sdi        in   1   serial data in, sampled on sclk rising edge
//  sdo        out  1   serial data out / ready-busy status
//  dump_addr  in   AW  word address for dump access
//  dump_we    in   1   write dump_din to dump_addr this cycle
//  dump_din   in   DW  dump write data
//  dump_dout  out  DW  array[dump_addr], registered, 1 clk latency
//  dirty      out  1   set by any committed serial write/erase
//  dirty_clr  in   1   clears dirty (frame has saved NVRAM)
// BEHAVIOUR
//  Reset: FSM=IDLE, sdo=1, write-enable latch (wen)=0, busy=0, dirty=0, dump_dout=0.
//   The array is NOT cleared by rst. Power-up content is all 1s.
//  Edge detect: sclk_l<=sclk each clk; rise = sclk & ~sclk_l. All serial actions happen on rise.
//   Edge detection adds 1 clk of latency.
//  scs low at any clk: FSM->IDLE, bit counters cleared, partial command discarded, sdo=1.
//   A pending WRITE/ERASE commits on this scs falling edge, but only if all bits were received.
//  FSM:
//   IDLE  : on rise with sdi=1 (start bit) -> OPC. Leading zeros are ignored.
//   OPC   : shift 2 bits -> ADDR.
//   ADDR  : shift AW bits MSB first. After the last bit, decode:
//           10 READ  -> RD, sdo=0 (dummy bit) from that rise;
//           01 WRITE -> WR; 11 ERASE -> arm erase, then HOLD;
//           00 with A[AW-1:AW-2]: 11 EWEN (wen=1), 00 EWDS (wen=0), 10 ERAL (arm), 01 WRAL -> WR;
//           EWEN/EWDS -> HOLD.
//   RD    : on each rise, sdo<=next data bit, MSB first, DW bits.
//           After bit 0: address+1 (wraps at 2^AW-1 -> 0) and continue with the next word (sequential read).
//   WR    : shift DW bits. After the last bit -> HOLD with the write armed; extra rises are ignored.
//   HOLD  : wait for scs low. Armed op with wen=1 -> BUSY. If wen=0, the op is dropped and no busy.
//  BUSY: counter loads BUSY_CNT and decrements each clk.
//   WRITE stores the word; ERASE stores all 1s; WRAL/ERAL step through addresses, one per clk.
//   If BUSY_CNT < 2^AW, BUSY lasts 2^AW clks.
//   During BUSY, IDLE ignores start bits. sdo=0 while scs=1 and busy; sdo=1 once done.
//  Each completed commit sets dirty. Set wins over a simultaneous dirty_clr.
//  dump_we has priority over a serial commit in the same clk.
//   The serial commit stalls 1 clk; the BUSY count is unaffected.
//  Reset mid-BUSY aborts the remaining ERAL/WRAL steps. Words already written keep their values.
// TESTING
//  dump_we addr 5 = 16'h1234, then READ addr 5 -> sdo: dummy 0, then 0001_0010_0011_0100 MSB first.
//  WRITE addr 3 = 16'hBEEF without EWEN -> addr 3 unchanged, dirty=0, sdo=1 on next scs high.
//  EWEN, WRITE 3 = BEEF -> sdo=0 for BUSY_CNT clks with scs high, then 1; dump addr 3 reads BEEF; dirty=1.
//  READ addr 63 for 2 words -> data of 63, then data of 0 (wrap).
//  WRAL 16'hA5A5, then ERASE addr 10 -> all words A5A5 except addr 10, which reads FFFF.
//  scs dropped after 9 of 16 WRITE data bits -> no change, FSM IDLE, no busy.
//  rst asserted mid-WRAL -> wen=0, sdo=1.

Source files
------------

// File: rtl/jtpang_eeprom93.sv
// 93C46-compatible x16 serial EEPROM responder with an NVRAM dump port and a save-request flag.
// Words are kept inverted so a zero-initialised RAM reads back as erased (all 1s).
module jtpang_eeprom93 #(
  parameter int unsigned DW       = 16,
  parameter int unsigned AW       = 6,
  parameter int unsigned BUSY_CNT = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scs,
  input  logic          sclk,
  input  logic          sdi,
  output logic          sdo,
  input  logic [AW-1:0] dump_addr,
  input  logic          dump_we,
  input  logic [DW-1:0] dump_din,
  output logic [DW-1:0] dump_dout,
  output logic          dirty,
  input  logic          dirty_clr
);

  localparam int unsigned DEPTH    = 1 << AW;
  localparam int unsigned BUSY_LEN = (BUSY_CNT < DEPTH) ? DEPTH : BUSY_CNT;
  localparam int unsigned CNTW     = $clog2(BUSY_LEN + 1);
  localparam int unsigned BCW      = $clog2(((DW > AW) ? DW : AW) + 1);
  localparam int unsigned IW       = $clog2(DW);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_OPC  = 3'd1;
  localparam logic [2:0] ST_ADDR = 3'd2;
  localparam logic [2:0] ST_RD   = 3'd3;
  localparam logic [2:0] ST_WR   = 3'd4;
  localparam logic [2:0] ST_HOLD = 3'd5;

  logic [DW-1:0]   mem_q [DEPTH];

  logic [2:0]      state_q,     state_d;
  logic            sclk_l_q,    sclk_l_d;
  logic [BCW-1:0]  bit_cnt_q,   bit_cnt_d;
  logic [IW-1:0]   rd_idx_q,    rd_idx_d;
  logic [1:0]      opc_q,       opc_d;
  logic [AW-1:0]   addr_q,      addr_d;
  logic [DW-1:0]   data_q,      data_d;
  logic            armed_q,     armed_d;
  logic            all_q,       all_d;
  logic            wen_q,       wen_d;
  logic            sdo_q,       sdo_d;
  logic [CNTW-1:0] busy_cnt_q,  busy_cnt_d;
  logic            wr_pend_q,   wr_pend_d;
  logic            wr_all_q,    wr_all_d;
  logic [AW-1:0]   wr_addr_q,   wr_addr_d;
  logic [DW-1:0]   wr_data_q,   wr_data_d;
  logic            dirty_q,     dirty_d;
  logic [DW-1:0]   dump_dout_q, dump_dout_d;

  logic            rise_c;
  logic            busy_c;
  logic            commit_c;
  logic            wr_done_c;
  logic [AW-1:0]   a_full_c;
  logic [DW-1:0]   rd_word_c;
  logic            mem_we_c;
  logic [AW-1:0]   mem_waddr_c;
  logic [DW-1:0]   mem_wdata_c;

  assign sdo       = sdo_q;
  assign dirty     = dirty_q;
  assign dump_dout = dump_dout_q;

  // Shared decode terms; the dump port always wins the single write port
  always_comb begin
    rise_c      = sclk & ~sclk_l_q;
    busy_c      = (busy_cnt_q != '0) | wr_pend_q;
    commit_c    = ~scs & (state_q == ST_HOLD) & armed_q & wen_q;
    wr_done_c   = wr_pend_q & ~dump_we & (~wr_all_q | (wr_addr_q == AW'(DEPTH - 1)));
    a_full_c    = {addr_q[AW-2:0], sdi};
    rd_word_c   = ~mem_q[addr_q];
    mem_we_c    = dump_we | wr_pend_q;
    mem_waddr_c = dump_we ? dump_addr : wr_addr_q;
    mem_wdata_c = dump_we ? dump_din  : wr_data_q;
  end

  // Next-state: serial command FSM, programming engine and status
  always_comb begin
    state_d     = state_q;
    sclk_l_d    = sclk;
    bit_cnt_d   = bit_cnt_q;
    rd_idx_d    = rd_idx_q;
    opc_d       = opc_q;
    addr_d      = addr_q;
    data_d      = data_q;
    armed_d     = armed_q;
    all_d       = all_q;
    wen_d       = wen_q;
    sdo_d       = sdo_q;
    busy_cnt_d  = busy_cnt_q;
    wr_pend_d   = wr_pend_q;
    wr_all_d    = wr_all_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    dirty_d     = dirty_q;
    dump_dout_d = ~mem_q[dump_addr];

    if (busy_cnt_q != '0) begin
      busy_cnt_d = busy_cnt_q - 1'b1;
    end

    // ERAL/WRAL walk one address per clk; a dump write stalls the walk
    if (wr_pend_q && !dump_we) begin
      if (wr_done_c) begin
        wr_pend_d = 1'b0;
      end else begin
        wr_addr_d = wr_addr_q + 1'b1;
      end
    end

    if (dirty_clr) begin
      dirty_d = 1'b0;
    end
    if (wr_done_c) begin
      dirty_d = 1'b1;
    end

    if (commit_c) begin
      busy_cnt_d = CNTW'(BUSY_LEN);
      wr_pend_d  = 1'b1;
      wr_all_d   = all_q;
      wr_addr_d  = all_q ? '0 : addr_q;
      wr_data_d  = data_q;
    end

    if (!scs) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      armed_d   = 1'b0;
      sdo_d     = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sdo_d = ~busy_c;
          if (rise_c && sdi && !busy_c) begin
            state_d   = ST_OPC;
            bit_cnt_d = '0;
            armed_d   = 1'b0;
          end
        end
        ST_OPC: begin
          sdo_d = 1'b1;
          if (rise_c) begin
            opc_d = {opc_q[0], sdi};
            if (bit_cnt_q == BCW'(1)) begin
              state_d   = ST_ADDR;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        ST_ADDR: begin
          sdo_d = 1'b1;
          if (rise_c) begin
            addr_d = a_full_c;
            if (bit_cnt_q == BCW'(AW - 1)) begin
              bit_cnt_d = '0;
              case (opc_q)
                2'b10: begin
                  state_d  = ST_RD;
                  rd_idx_d = IW'(DW - 1);
                  sdo_d    = 1'b0;
                end
                2'b01: begin
                  state_d = ST_WR;
                  all_d   = 1'b0;
                end
                2'b11: begin
                  state_d = ST_HOLD;
                  armed_d = 1'b1;
                  all_d   = 1'b0;
                  data_d  = '1;
                end
                default: begin
                  // Extended opcodes live in the two address MSBs
                  case (a_full_c[AW-1 -: 2])
                    2'b11: begin
                      wen_d   = 1'b1;
                      state_d = ST_HOLD;
                    end
                    2'b00: begin
                      wen_d   = 1'b0;
                      state_d = ST_HOLD;
                    end
                    2'b10: begin
                      state_d = ST_HOLD;
                      armed_d = 1'b1;
                      all_d   = 1'b1;
                      data_d  = '1;
                    end
                    default: begin
                      state_d = ST_WR;
                      all_d   = 1'b1;
                    end
                  endcase
                end
              endcase
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        ST_RD: begin
          if (rise_c) begin
            sdo_d = rd_word_c[rd_idx_q];
            if (rd_idx_q == '0) begin
              addr_d   = addr_q + 1'b1;
              rd_idx_d = IW'(DW - 1);
            end else begin
              rd_idx_d = rd_idx_q - 1'b1;
            end
          end
        end
        ST_WR: begin
          sdo_d = 1'b1;
          if (rise_c) begin
            data_d = {data_q[DW-2:0], sdi};
            if (bit_cnt_q == BCW'(DW - 1)) begin
              state_d = ST_HOLD;
              armed_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          sdo_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Storage array: not touched by reset
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[mem_waddr_c] <= ~mem_wdata_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sclk_l_q    <= 1'b0;
      bit_cnt_q   <= '0;
      rd_idx_q    <= '0;
      opc_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      armed_q     <= 1'b0;
      all_q       <= 1'b0;
      wen_q       <= 1'b0;
      sdo_q       <= 1'b1;
      busy_cnt_q  <= '0;
      wr_pend_q   <= 1'b0;
      wr_all_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      dirty_q     <= 1'b0;
      dump_dout_q <= '0;
    end else begin
      state_q     <= state_d;
      sclk_l_q    <= sclk_l_d;
      bit_cnt_q   <= bit_cnt_d;
      rd_idx_q    <= rd_idx_d;
      opc_q       <= opc_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      armed_q     <= armed_d;
      all_q       <= all_d;
      wen_q       <= wen_d;
      sdo_q       <= sdo_d;
      busy_cnt_q  <= busy_cnt_d;
      wr_pend_q   <= wr_pend_d;
      wr_all_q    <= wr_all_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      dirty_q     <= dirty_d;
      dump_dout_q <= dump_dout_d;
    end
  end

endmodule

// File: tb/tb_jtpang_eeprom93.sv
// Bench for jtpang_eeprom93: bit-bangs 93C46 commands and compares against an array model.
module tb_jtpang_eeprom93;
  localparam int DW = 16;
  localparam int AW = 6;
  localparam int DEPTH = 64;
  localparam int BUSY_CNT = 200;

  logic          clk = 1'b0;
  logic          rst, scs, sclk, sdi, sdo;
  logic [AW-1:0] dump_addr;
  logic          dump_we;
  logic [DW-1:0] dump_din, dump_dout;
  logic          dirty, dirty_clr;

  logic [DW-1:0] model [DEPTH];
  bit            m_wen;
  int            checks = 0;
  int            passed = 0;

  jtpang_eeprom93 #(.DW(DW), .AW(AW), .BUSY_CNT(BUSY_CNT)) dut (
    .clk(clk), .rst(rst), .scs(scs), .sclk(sclk), .sdi(sdi), .sdo(sdo),
    .dump_addr(dump_addr), .dump_we(dump_we), .dump_din(dump_din),
    .dump_dout(dump_dout), .dirty(dirty), .dirty_clr(dirty_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    sdi = b; sclk = 1'b0; tick(2);
    sclk = 1'b1; tick(2);
    s = sdo;
  endtask

  task automatic send(input logic [31:0] v, input int n);
    logic s;
    for (int i = n - 1; i >= 0; i--) clock_bit(v[i], s);
  endtask

  task automatic begin_cmd(input logic [1:0] opc, input logic [AW-1:0] a, output logic dummy);
    scs = 1'b1; tick(2);
    send({24'd0, 1'b1, opc, a[AW-1:1]}, 8);
    clock_bit(a[0], dummy);
  endtask

  task automatic end_cmd();
    scs = 1'b0; sclk = 1'b0; sdi = 1'b0;
    tick(1);
  endtask

  task automatic recv_word(output logic [DW-1:0] w);
    logic s;
    for (int i = DW - 1; i >= 0; i--) begin
      clock_bit(1'b0, s);
      w[i] = s;
    end
  endtask

  task automatic dump_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    dump_addr = a; dump_din = d; dump_we = 1'b1; tick(1);
    dump_we = 1'b0;
    model[a] = d;
  endtask

  task automatic dump_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
    dump_addr = a; tick(2);
    d = dump_dout;
  endtask

  // Raise scs and count clocks with sdo low (busy), bounded
  task automatic wait_busy(output int n);
    scs = 1'b1; n = 0; tick(1);
    while (sdo === 1'b0 && n < 5000) begin
      n++; tick(1);
    end
    scs = 1'b0; tick(1);
  endtask

  task automatic ewen();
    logic s;
    begin_cmd(2'b00, 6'b110000, s); end_cmd(); m_wen = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; scs = 0; sclk = 0; sdi = 0; dump_we = 0; dump_addr = '0;
    dump_din = '0; dirty_clr = 0; m_wen = 0;
    tick(3);
    checks++; if (sdo !== 1'b1) $display("FAIL reset_sdo: got %b want 1", sdo); else passed++;
    checks++; if (dirty !== 1'b0) $display("FAIL reset_dirty: got %b want 0", dirty); else passed++;
    checks++; if (dump_dout !== '0) $display("FAIL reset_dump_dout: got %h want 0", dump_dout); else passed++;
    rst = 1'b0; tick(2);
    checks++; if (sdo !== 1'b1) $display("FAIL post_reset_sdo: got %b want 1", sdo); else passed++;
    for (int a = 0; a < DEPTH; a++) dump_write(AW'(a), DW'($urandom));
  endtask

  task automatic test_dump_read();
    logic dm; logic [DW-1:0] w; logic [AW-1:0] a;
    dump_write(6'd5, 16'h1234);
    begin_cmd(2'b10, 6'd5, dm); recv_word(w); end_cmd();
    checks++; if (dm !== 1'b0) $display("FAIL read5_dummy: got %b want 0", dm); else passed++;
    checks++; if (w !== 16'h1234) $display("FAIL read5_data: got %h want 1234", w); else passed++;
    for (int k = 0; k < 4; k++) begin
      a = AW'($urandom);
      dump_write(a, DW'($urandom));
      dump_write(a ^ 6'd1, DW'($urandom));
      dump_read(a, w);
      checks++; if (w !== model[a]) $display("FAIL dump_rd a=%0d: got %h want %h", a, w, model[a]); else passed++;
      begin_cmd(2'b10, a ^ 6'd1, dm); recv_word(w); end_cmd();
      checks++; if (w !== model[a ^ 6'd1]) $display("FAIL ser_rd a=%0d: got %h want %h", a ^ 6'd1, w, model[a ^ 6'd1]); else passed++;
    end
  endtask

  task automatic test_write_no_ewen();
    logic dm; logic [DW-1:0] w;
    begin_cmd(2'b01, 6'd3, dm); send({16'd0, 16'hBEEF}, 16); end_cmd();
    scs = 1'b1; tick(2);
    checks++; if (sdo !== 1'b1) $display("FAIL noewen_sdo: got %b want 1", sdo); else passed++;
    scs = 1'b0; tick(1);
    dump_read(6'd3, w);
    checks++; if (w !== model[3]) $display("FAIL noewen_data: got %h want %h", w, model[3]); else passed++;
    checks++; if (dirty !== 1'b0) $display("FAIL noewen_dirty: got %b want 0", dirty); else passed++;
  endtask

  task automatic test_write_ewen();
    logic dm; logic [DW-1:0] w, d; logic [AW-1:0] a; int n;
    ewen();
    begin_cmd(2'b01, 6'd3, dm); send({16'd0, 16'hBEEF}, 16); end_cmd();
    model[3] = 16'hBEEF;
    wait_busy(n);
    checks++; if (n < BUSY_CNT - 3 || n > BUSY_CNT + 2) $display("FAIL write_busy_len: got %0d want ~%0d", n, BUSY_CNT); else passed++;
    dump_read(6'd3, w);
    checks++; if (w !== 16'hBEEF) $display("FAIL write_data: got %h want beef", w); else passed++;
    checks++; if (dirty !== 1'b1) $display("FAIL write_dirty: got %b want 1", dirty); else passed++;
    dirty_clr = 1'b1; tick(1); dirty_clr = 1'b0; tick(1);
    checks++; if (dirty !== 1'b0) $display("FAIL dirty_clr: got %b want 0", dirty); else passed++;
    for (int k = 0; k < 3; k++) begin
      a = AW'($urandom); d = DW'($urandom);
      begin_cmd(2'b01, a, dm); send({16'd0, d}, 16); end_cmd();
      model[a] = d;
      wait_busy(n);
      checks++; if (n < BUSY_CNT - 3 || n > BUSY_CNT + 2) $display("FAIL rnd_busy_len: got %0d want ~%0d", n, BUSY_CNT); else passed++;
      dump_read(a, w);
      checks++; if (w !== model[a]) $display("FAIL rnd_write a=%0d: got %h want %h", a, w, model[a]); else passed++;
    end
  endtask

  task automatic test_read_wrap();
    logic dm; logic [DW-1:0] w0, w1;
    begin_cmd(2'b10, 6'd63, dm); recv_word(w0); recv_word(w1); end_cmd();
    checks++; if (dm !== 1'b0) $display("FAIL wrap_dummy: got %b want 0", dm); else passed++;
    checks++; if (w0 !== model[63]) $display("FAIL wrap_w63: got %h want %h", w0, model[63]); else passed++;
    checks++; if (w1 !== model[0]) $display("FAIL wrap_w0: got %h want %h", w1, model[0]); else passed++;
  endtask

  task automatic test_wral_erase();
    logic dm; logic [DW-1:0] w; int n;
    begin_cmd(2'b00, 6'b010000, dm); send({16'd0, 16'hA5A5}, 16); end_cmd();
    for (int a = 0; a < DEPTH; a++) model[a] = 16'hA5A5;
    wait_busy(n);
    checks++; if (n < BUSY_CNT - 3 || n > BUSY_CNT + 2) $display("FAIL wral_busy_len: got %0d want ~%0d", n, BUSY_CNT); else passed++;
    begin_cmd(2'b11, 6'd10, dm); end_cmd();
    model[10] = 16'hFFFF;
    wait_busy(n);
    checks++; if (n < BUSY_CNT - 3 || n > BUSY_CNT + 2) $display("FAIL erase_busy_len: got %0d want ~%0d", n, BUSY_CNT); else passed++;
    for (int a = 0; a < DEPTH; a++) begin
      dump_read(AW'(a), w);
      checks++; if (w !== model[a]) $display("FAIL wral_scan a=%0d: got %h want %h", a, w, model[a]); else passed++;
    end
  endtask

  task automatic test_partial();
    logic dm; logic [DW-1:0] w;
    dirty_clr = 1'b1; tick(1); dirty_clr = 1'b0;
    begin_cmd(2'b01, 6'd7, dm); send(32'h155, 9); end_cmd();
    scs = 1'b1; tick(3);
    checks++; if (sdo !== 1'b1) $display("FAIL partial_busy: got sdo %b want 1", sdo); else passed++;
    scs = 1'b0; tick(1);
    dump_read(6'd7, w);
    checks++; if (w !== model[7]) $display("FAIL partial_data: got %h want %h", w, model[7]); else passed++;
    checks++; if (dirty !== 1'b0) $display("FAIL partial_dirty: got %b want 0", dirty); else passed++;
    begin_cmd(2'b10, 6'd7, dm); recv_word(w); end_cmd();
    checks++; if (dm !== 1'b0 || w !== model[7]) $display("FAIL partial_then_read: got %b/%h want 0/%h", dm, w, model[7]); else passed++;
  endtask

  task automatic test_dump_priority();
    logic dm; logic [DW-1:0] w, d1, d2; int n;
    d1 = DW'($urandom); d2 = DW'($urandom);
    begin_cmd(2'b01, 6'd20, dm); send({16'd0, d1}, 16);
    scs = 1'b0; sclk = 1'b0; sdi = 1'b0;
    dump_addr = 6'd21; dump_din = d2; dump_we = 1'b1; tick(2);
    dump_we = 1'b0;
    model[20] = d1; model[21] = d2;
    wait_busy(n);
    checks++; if (n < BUSY_CNT - 3 || n > BUSY_CNT + 2) $display("FAIL prio_busy_len: got %0d want ~%0d", n, BUSY_CNT); else passed++;
    dump_read(6'd20, w);
    checks++; if (w !== d1) $display("FAIL prio_serial: got %h want %h", w, d1); else passed++;
    dump_read(6'd21, w);
    checks++; if (w !== d2) $display("FAIL prio_dump: got %h want %h", w, d2); else passed++;
    checks++; if (dirty !== 1'b1) $display("FAIL prio_dirty: got %b want 1", dirty); else passed++;
  endtask

  task automatic test_reset_mid_wral();
    logic dm; logic [DW-1:0] w;
    begin_cmd(2'b00, 6'b010000, dm); send({16'd0, 16'h1111}, 16); end_cmd();
    tick(8);
    rst = 1'b1; tick(2); rst = 1'b0; tick(1);
    m_wen = 0; model[0] = 16'h1111;
    dump_read(6'd0, w);
    checks++; if (w !== 16'h1111) $display("FAIL rstwral_first: got %h want 1111", w); else passed++;
    dump_read(6'd63, w);
    checks++; if (w !== model[63]) $display("FAIL rstwral_last: got %h want %h", w, model[63]); else passed++;
    scs = 1'b1; tick(2);
    checks++; if (sdo !== 1'b1) $display("FAIL rstwral_sdo: got %b want 1", sdo); else passed++;
    checks++; if (dirty !== 1'b0) $display("FAIL rstwral_dirty: got %b want 0", dirty); else passed++;
    scs = 1'b0; tick(1);
    begin_cmd(2'b01, 6'd30, dm); send({16'd0, ~model[30]}, 16); end_cmd();
    scs = 1'b1; tick(2);
    checks++; if (sdo !== 1'b1) $display("FAIL rstwral_wen_busy: got sdo %b want 1", sdo); else passed++;
    scs = 1'b0; tick(1);
    dump_read(6'd30, w);
    checks++; if (w !== model[30]) $display("FAIL rstwral_wen_data: got %h want %h", w, model[30]); else passed++;
  endtask

  initial begin
    test_reset();
    test_dump_read();
    test_write_no_ewen();
    test_write_ewen();
    test_read_wrap();
    test_wral_erase();
    test_partial();
    test_dump_priority();
    test_reset_mid_wral();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
